// File: rtl/oai_slice_result_checker_if.sv
// Beat interface of the slice result checker: captured operand/result beat in, buffered C out.
// Both sides use valid/ready: a beat moves on a rising edge where valid and ready are both 1; the producer holds its data stable while valid is high and ready is low.
interface oai_slice_result_checker_if #(
  parameter int WIDTH = 41
);
  localparam int NSLICE = WIDTH / 4;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic [WIDTH-1:0]  in_c;
  logic [WIDTH-1:0]  in_mask;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_c;
  logic [NSLICE-1:0] out_err_slices;

  modport master (
    output in_valid, in_a, in_b, in_c, in_mask, out_ready,
    input  in_ready, out_valid, out_c, out_err_slices
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_mask, out_ready,
    output in_ready, out_valid, out_c, out_err_slices
  );
endinterface

// File: rtl/oai_slice_result_checker.sv
// Recomputes the INV/OAI222 slice outputs for each beat, flags failing slices, buffers C in a
// 2-entry FIFO and tracks a saturating mismatch count plus sticky first-failure info.
module oai_slice_result_checker #(
  parameter int WIDTH = 41,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  oai_slice_result_checker_if.slave    bus,
  input  logic                         clr,
  output logic [CNT_W-1:0]             err_count,
  output logic                         err_sticky,
  output logic [3:0]                   first_err_slice
);
  localparam int NSLICE = WIDTH / 4;
  localparam int CHK_W  = 4 * NSLICE;

  logic [CHK_W-1:0]  expected;
  logic [NSLICE-1:0] mismatch;
  logic [3:0]        low_idx;

  // Bits at or above CHK_W belong to no slice and are never compared.
  always_comb begin
    expected = '0;
    mismatch = '0;
    low_idx  = '0;
    for (int k = 0; k < NSLICE; k++) begin
      expected[4*k]   = ~bus.in_a[4*k];
      expected[4*k+1] = ~bus.in_b[4*k];
      expected[4*k+2] = ~bus.in_b[4*k+1];
      expected[4*k+3] = ~((bus.in_a[4*k+1] | bus.in_a[4*k+2]) &
                          (bus.in_b[4*k+1] | bus.in_b[4*k+2]) &
                          (bus.in_a[4*k+3] | bus.in_b[4*k+3]));
      mismatch[k] = |((bus.in_c[4*k +: 4] ^ expected[4*k +: 4]) & ~bus.in_mask[4*k +: 4]);
    end
    for (int k = NSLICE - 1; k >= 0; k--) begin
      if (mismatch[k]) low_idx = 4'(k);
    end
  end

  logic [WIDTH-1:0]  mem_c [2];
  logic [NSLICE-1:0] mem_e [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  // in_ready depends on occupancy only, so a full buffer never refills in the cycle it drains.
  assign bus.in_ready       = (count != 2'd2);
  assign bus.out_valid      = (count != 2'd0);
  assign bus.out_c          = mem_c[rd_ptr];
  assign bus.out_err_slices = mem_e[rd_ptr];
  assign push               = bus.in_valid & bus.in_ready;
  assign pop                = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_c[0] <= '0;
      mem_c[1] <= '0;
      mem_e[0] <= '0;
      mem_e[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        mem_c[wr_ptr] <= bus.in_c;
        mem_e[wr_ptr] <= mismatch;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (!push && pop) count <= count - 2'd1;
    end
  end

  // clr takes effect before a mismatching beat accepted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count       <= '0;
      err_sticky      <= 1'b0;
      first_err_slice <= 4'd0;
    end else begin
      if (clr) begin
        err_count       <= '0;
        err_sticky      <= 1'b0;
        first_err_slice <= 4'd0;
      end
      if (push && (|mismatch)) begin
        if (clr)                err_count <= CNT_W'(1);
        else if (~&err_count)   err_count <= err_count + CNT_W'(1);
        if (clr || !err_sticky) begin
          err_sticky      <= 1'b1;
          first_err_slice <= low_idx;
        end
      end
    end
  end
endmodule

// File: tb/tb_oai_slice_result_checker.sv
// Bench for oai_slice_result_checker: directed cases plus random traffic against a queue model.
module tb_oai_slice_result_checker;
  localparam int WIDTH  = 41;
  localparam int NSLICE = WIDTH / 4;
  localparam int CNT_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  bit   cmp_en = 1'b0;
  always #5 clk = ~clk;

  oai_slice_result_checker_if #(.WIDTH(WIDTH)) bus ();
  oai_slice_result_checker_if #(.WIDTH(WIDTH)) sat_bus ();

  logic [CNT_W-1:0] err_count;
  logic             err_sticky;
  logic [3:0]       first_err_slice;
  logic [1:0]       sat_err_count;
  logic             sat_err_sticky;
  logic [3:0]       sat_first_err_slice;

  assign sat_bus.in_valid  = bus.in_valid;
  assign sat_bus.in_a      = bus.in_a;
  assign sat_bus.in_b      = bus.in_b;
  assign sat_bus.in_c      = bus.in_c;
  assign sat_bus.in_mask   = bus.in_mask;
  assign sat_bus.out_ready = bus.out_ready;

  oai_slice_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clr(clr),
    .err_count(err_count), .err_sticky(err_sticky), .first_err_slice(first_err_slice)
  );

  oai_slice_result_checker #(.WIDTH(WIDTH), .CNT_W(2)) sat_dut (
    .clk(clk), .rst_n(rst_n), .bus(sat_bus), .clr(clr),
    .err_count(sat_err_count), .err_sticky(sat_err_sticky), .first_err_slice(sat_first_err_slice)
  );

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] model_expect(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] e;
    e = '0;
    for (int k = 0; k < NSLICE; k++) begin
      int j;
      j = 4 * k;
      e[j]   = !a[j];
      e[j+1] = !b[j];
      e[j+2] = !b[j+1];
      e[j+3] = !((a[j+1] || a[j+2]) && (b[j+1] || b[j+2]) && (a[j+3] || b[j+3]));
    end
    return e;
  endfunction

  function automatic logic [NSLICE-1:0] model_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                     input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0]  diff;
    logic [NSLICE-1:0] f;
    diff = (c ^ model_expect(a, b)) & ~m;
    f = '0;
    for (int k = 0; k < NSLICE; k++) f[k] = (((diff >> (4 * k)) & 41'hF) != 0);
    return f;
  endfunction

  logic [WIDTH+NSLICE-1:0] exp_q[$];
  int m_cnt, m_sat, m_first;
  bit m_sticky;
  bit m_acc, m_pop;
  logic [NSLICE-1:0] m_flags;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 0; m_sat = 0; m_first = 0; m_sticky = 0;
    end else begin
      m_acc   = bus.in_valid && (exp_q.size() < 2);
      m_pop   = (exp_q.size() > 0) && bus.out_ready;
      m_flags = model_flags(bus.in_a, bus.in_b, bus.in_c, bus.in_mask);
      if (m_pop) void'(exp_q.pop_front());
      if (m_acc) exp_q.push_back({bus.in_c, m_flags});
      if (clr) begin
        m_cnt = 0; m_sat = 0; m_first = 0; m_sticky = 0;
      end
      if (m_acc && m_flags != 0) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (m_sat < 3) m_sat++;
        if (!m_sticky) begin
          m_sticky = 1;
          for (int k = NSLICE - 1; k >= 0; k--) if (m_flags[k]) m_first = k;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
      check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check("out_c", 64'(bus.out_c), 64'(exp_q[0][WIDTH+NSLICE-1:NSLICE]));
        check("out_err_slices", 64'(bus.out_err_slices), 64'(exp_q[0][NSLICE-1:0]));
      end
      check("err_count", 64'(err_count), 64'(m_cnt));
      check("err_sticky", 64'(err_sticky), 64'(m_sticky));
      check("first_err_slice", 64'(first_err_slice), 64'(m_first));
      check("sat_err_count", 64'(sat_err_count), 64'(m_sat));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] m, input logic cl);
    bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_mask = m;
    bus.in_valid = 1'b1; clr = cl;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic step(output bit acc);
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    @(posedge clk); #1;
  endtask

  function automatic logic [WIDTH-1:0] rand41();
    return WIDTH'({$urandom, $urandom});
  endfunction

  // ---------------- stimulus ----------------
  bit acc;
  logic [WIDTH-1:0] ra, rb, rc, rm;

  initial begin
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_mask = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_c", 64'(bus.out_c), 64'd0);
    check("reset out_err_slices", 64'(bus.out_err_slices), 64'd0);
    check("reset err_count", 64'(err_count), 64'd0);
    check("reset first_err_slice", 64'(first_err_slice), 64'd0);

    // all-zero operands give all-ones expected; bit 40 is unchecked
    drive_beat('0, '0, 41'h1FF_FFFF_FFFF, '0, 1'b0);
    check("t1 out_c", 64'(bus.out_c), 64'h1FF_FFFF_FFFF);
    check("t1 out_err_slices", 64'(bus.out_err_slices), 64'd0);
    check("t1 err_count", 64'(err_count), 64'd0);

    drive_beat(41'hE, 41'h2, 41'h0FF_FFFF_FFF3, '0, 1'b0);
    check("t2 good slices", 64'(bus.out_err_slices), 64'd0);
    drive_beat(41'hE, 41'h2, 41'h0FF_FFFF_FFF7, '0, 1'b0);
    check("t2 bad slices", 64'(bus.out_err_slices), 64'h001);
    check("t2 err_count", 64'(err_count), 64'd1);
    check("t2 err_sticky", 64'(err_sticky), 64'd1);
    check("t2 first", 64'(first_err_slice), 64'd0);

    // slice 3 error hidden by mask, slice 7 real; clr in the same cycle
    drive_beat('0, '0, 41'h0FF_EFFF_EFFF, 41'h1000, 1'b1);
    check("t3 slices", 64'(bus.out_err_slices), 64'h080);
    check("t3 first", 64'(first_err_slice), 64'd7);
    check("t3 err_count", 64'(err_count), 64'd1);

    repeat (5) drive_beat('0, '0, '0, '0, 1'b0);
    check("t5 sat count", 64'(sat_err_count), 64'd3);
    check("t5 wide count", 64'(err_count), 64'd6);
    drive_beat('0, '0, '0, '0, 1'b1);
    check("t5 clr sat count", 64'(sat_err_count), 64'd1);
    check("t5 clr wide count", 64'(err_count), 64'd1);

    // back-pressure: third beat must wait
    repeat (2) @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = '0; bus.in_b = '0; bus.in_mask = '0;
    bus.in_c = 41'h1; step(acc); check("t4 acc0", 64'(acc), 64'd1);
    bus.in_c = 41'h2; step(acc); check("t4 acc1", 64'(acc), 64'd1);
    check("t4 in_ready full", 64'(bus.in_ready), 64'd0);
    bus.in_c = 41'h3; step(acc); check("t4 acc2 held", 64'(acc), 64'd0);
    step(acc); check("t4 acc2 still held", 64'(acc), 64'd0);
    check("t4 head stable", 64'(bus.out_c), 64'h1);
    bus.out_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 10 && !acc; i++) step(acc);
    check("t4 third accepted", 64'(acc), 64'd1);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // reset with two beats buffered
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_c = 41'h5; step(acc);
    bus.in_c = 41'h6; step(acc);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6 out_valid", 64'(bus.out_valid), 64'd0);
    check("t6 in_ready", 64'(bus.in_ready), 64'd1);
    check("t6 err_count", 64'(err_count), 64'd0);
    check("t6 err_sticky", 64'(err_sticky), 64'd0);
    check("t6 out_c", 64'(bus.out_c), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // random traffic
    acc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!(bus.in_valid && !acc)) begin
        ra = rand41(); rb = rand41();
        rm = rand41() & rand41() & rand41();
        if ($urandom_range(0, 7) == 0) rc = rand41();
        else begin
          rc = model_expect(ra, rb);
          if ($urandom_range(0, 3) == 0) rc = rc ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        end
        bus.in_a = ra; bus.in_b = rb; bus.in_c = rc; bus.in_mask = rm;
        bus.in_valid = ($urandom_range(0, 9) < 7);
      end
      bus.out_ready = ($urandom_range(0, 9) < 6);
      clr = ($urandom_range(0, 49) == 0);
      step(acc);
      clr = 1'b0;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("drained", 64'(bus.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
